// File: rtl/axi_lite_front.sv
// AXI4-Lite slave front-end for prewrapped: serialises AXI transactions into the flat
// single-cycle write command / fixed-latency read capture interface.
module axi_lite_front #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] IDLE_ADDR = 32'd0,
    parameter int          RD_LAT    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_wvalid,
    output logic              s_wready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic [1:0]        s_bresp,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [ADDR_W-1:0] s_araddr,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic [31:0]       axi_wr_addr,
    output logic [31:0]       axi_wr_msg,
    output logic [31:0]       axi_rd_addr,
    input  logic [31:0]       axi_rd_msg
);

    typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_RESP, RD_HOLD, RD_RESP} state_t;

    localparam logic [3:0] LAT_M1      = 4'(RD_LAT - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [31:0] word_of(input logic [ADDR_W-1:0] a);
        return 32'(a[ADDR_W-1:2]);
    endfunction

    state_t            state_q, state_d;
    logic              run_q;
    logic              aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic              prio_rd_q, prio_rd_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       wr_addr_q, wr_addr_d, wr_msg_q, wr_msg_d;
    logic [31:0]       rd_addr_q, rd_addr_d, rdata_q, rdata_d;
    logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
    logic [ADDR_W-1:0] awaddr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;

    logic              idle, ar_ok, ar_req, wr_complete, contention, grant_wr, grant_rd;
    logic [ADDR_W-1:0] cur_awaddr;
    logic [31:0]       cur_wdata;
    logic [3:0]        cur_wstrb;
    logic              wr_err, rd_err;

    // Handshake arbitration: a read may only start when no write beat is parked, and a
    // complete write racing a read is settled by the alternating priority flag.
    always_comb begin
        idle        = run_q && (state_q == IDLE);
        ar_ok       = idle && !aw_got_q && !w_got_q;
        ar_req      = ar_ok && s_arvalid;
        wr_complete = idle && (aw_got_q || s_awvalid) && (w_got_q || s_wvalid);
        contention  = wr_complete && ar_req;
        grant_wr    = wr_complete && !(ar_req && prio_rd_q);
        grant_rd    = ar_req && !(wr_complete && !prio_rd_q);
        s_awready   = idle && !aw_got_q && !grant_rd;
        s_wready    = idle && !w_got_q && !grant_rd;
        s_arready   = ar_ok && !(wr_complete && !prio_rd_q);
        cur_awaddr  = aw_got_q ? awaddr_q : s_awaddr;
        cur_wdata   = w_got_q ? wdata_q : s_wdata;
        cur_wstrb   = w_got_q ? wstrb_q : s_wstrb;
        wr_err      = (cur_wstrb != 4'hF) || (cur_awaddr[1:0] != 2'b00) ||
                      (word_of(cur_awaddr) == IDLE_ADDR);
        rd_err      = (s_araddr[1:0] != 2'b00) || (word_of(s_araddr) == IDLE_ADDR);
    end

    always_comb begin
        state_d   = state_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        prio_rd_d = prio_rd_q;
        cnt_d     = cnt_q;
        wr_addr_d = wr_addr_q;
        wr_msg_d  = wr_msg_q;
        rd_addr_d = rd_addr_q;
        rdata_d   = rdata_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        case (state_q)
            IDLE: begin
                if (contention) prio_rd_d = !prio_rd_q;
                if (grant_wr) begin
                    aw_got_d = 1'b0;
                    w_got_d  = 1'b0;
                    if (wr_err) begin
                        state_d  = WR_RESP;
                        bvalid_d = 1'b1;
                        bresp_d  = RESP_SLVERR;
                    end else begin
                        state_d   = WR_ISSUE;
                        wr_addr_d = word_of(cur_awaddr);
                        wr_msg_d  = cur_wdata;
                    end
                end else begin
                    aw_got_d = aw_got_q || (s_awvalid && s_awready);
                    w_got_d  = w_got_q || (s_wvalid && s_wready);
                    if (grant_rd) begin
                        if (rd_err) begin
                            state_d  = RD_RESP;
                            rvalid_d = 1'b1;
                            rresp_d  = RESP_SLVERR;
                            rdata_d  = 32'd0;
                        end else begin
                            state_d   = RD_HOLD;
                            rd_addr_d = word_of(s_araddr);
                            cnt_d     = LAT_M1;
                        end
                    end
                end
            end
            WR_ISSUE: begin
                wr_addr_d = IDLE_ADDR;
                wr_msg_d  = 32'd0;
                state_d   = WR_RESP;
                bvalid_d  = 1'b1;
                bresp_d   = RESP_OKAY;
            end
            WR_RESP: begin
                if (s_bready) begin
                    bvalid_d = 1'b0;
                    bresp_d  = RESP_OKAY;
                    state_d  = IDLE;
                end
            end
            RD_HOLD: begin
                if (cnt_q == 4'd0) begin
                    rdata_d   = axi_rd_msg;
                    rresp_d   = RESP_OKAY;
                    rvalid_d  = 1'b1;
                    rd_addr_d = IDLE_ADDR;
                    state_d   = RD_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RD_RESP: begin
                if (s_rready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // run_q holds every ready low while reset is asserted and for the release cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            run_q     <= 1'b0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            prio_rd_q <= 1'b0;
            cnt_q     <= 4'd0;
            wr_addr_q <= IDLE_ADDR;
            wr_msg_q  <= 32'd0;
            rd_addr_q <= IDLE_ADDR;
            rdata_q   <= 32'd0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            run_q     <= 1'b1;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            prio_rd_q <= prio_rd_d;
            cnt_q     <= cnt_d;
            wr_addr_q <= wr_addr_d;
            wr_msg_q  <= wr_msg_d;
            rd_addr_q <= rd_addr_d;
            rdata_q   <= rdata_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (s_awvalid && s_awready) awaddr_q <= s_awaddr;
        if (s_wvalid && s_wready) begin
            wdata_q <= s_wdata;
            wstrb_q <= s_wstrb;
        end
    end

    assign s_bvalid    = bvalid_q;
    assign s_bresp     = bresp_q;
    assign s_rvalid    = rvalid_q;
    assign s_rdata     = rdata_q;
    assign s_rresp     = rresp_q;
    assign axi_wr_addr = wr_addr_q;
    assign axi_wr_msg  = wr_msg_q;
    assign axi_rd_addr = rd_addr_q;

endmodule

// File: tb/tb_axi_lite_front.sv
// Directed bench for axi_lite_front: vector table of single transactions plus
// hand-written sequences for split write channels, contention and mid-read reset.
module tb_axi_lite_front;

    localparam int          ADDR_W = 32;
    localparam int          RD_LAT = 2;
    localparam logic [31:0] IDLE   = 32'd0;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              s_awvalid = 1'b0, s_awready;
    logic [ADDR_W-1:0] s_awaddr = '0;
    logic              s_wvalid = 1'b0, s_wready;
    logic [31:0]       s_wdata = '0;
    logic [3:0]        s_wstrb = '0;
    logic              s_bvalid, s_bready = 1'b1;
    logic [1:0]        s_bresp;
    logic              s_arvalid = 1'b0, s_arready;
    logic [ADDR_W-1:0] s_araddr = '0;
    logic              s_rvalid, s_rready = 1'b0;
    logic [31:0]       s_rdata;
    logic [1:0]        s_rresp;
    logic [31:0]       axi_wr_addr, axi_wr_msg, axi_rd_addr;
    logic [31:0]       axi_rd_msg = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axi_lite_front #(.ADDR_W(ADDR_W), .IDLE_ADDR(IDLE), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .axi_wr_addr(axi_wr_addr), .axi_wr_msg(axi_wr_msg),
        .axi_rd_addr(axi_rd_addr), .axi_rd_msg(axi_rd_msg)
    );

    typedef struct {
        string       name;
        logic        is_rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          stall;
        logic        ok;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at the negedge of the first cycle after the final AW/W handshake.
    task automatic watch_write(input string name, input logic [31:0] word,
                               input logic [31:0] msg, input logic ok);
        int lat = 99;
        int issues = 0;
        for (int k = 1; k <= 20; k++) begin
            if (axi_wr_addr !== IDLE) begin
                issues++;
                check({name, " issue addr"}, axi_wr_addr, word);
                check({name, " issue msg"}, axi_wr_msg, msg);
            end else if (axi_wr_msg !== 32'd0) begin
                check({name, " idle msg"}, axi_wr_msg, 32'd0);
            end
            if (s_bvalid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        check({name, " b latency"}, lat, ok ? 2 : 1);
        check({name, " issue cycles"}, issues, ok ? 1 : 0);
        check({name, " bresp"}, s_bresp, ok ? 2'b00 : 2'b10);
        @(negedge clk);
        check({name, " bvalid dropped"}, s_bvalid, 1'b0);
        check({name, " wr_addr idle"}, axi_wr_addr, IDLE);
    endtask

    // Called at the negedge of the first cycle after the AR handshake.
    task automatic watch_read(input string name, input logic [31:0] word, input logic [31:0] msg,
                              input int stall, input logic ok);
        int lat = 99;
        int holds = 0;
        logic stable = 1'b1;
        logic [31:0] held;
        s_rready = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            axi_rd_msg = (k >= RD_LAT) ? msg : 32'hBAD0_0000 + 32'(k);
            if (axi_rd_addr !== IDLE) begin
                holds++;
                check({name, " hold addr"}, axi_rd_addr, word);
            end
            if (s_rvalid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        check({name, " r latency"}, lat, ok ? RD_LAT + 1 : 1);
        check({name, " hold cycles"}, holds, ok ? RD_LAT : 0);
        check({name, " rresp"}, s_rresp, ok ? 2'b00 : 2'b10);
        check({name, " rdata"}, s_rdata, ok ? msg : 32'd0);
        held = s_rdata;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            axi_rd_msg = ~axi_rd_msg;
            if (!s_rvalid || s_rdata !== held) stable = 1'b0;
        end
        if (stall > 0) check({name, " stall stable"}, stable, 1'b1);
        s_rready = 1'b1;
        @(negedge clk);
        check({name, " rvalid dropped"}, s_rvalid, 1'b0);
        check({name, " rd_addr idle"}, axi_rd_addr, IDLE);
    endtask

    task automatic write_txn(input string name, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic ok);
        s_awvalid = 1'b1; s_awaddr = addr;
        s_wvalid = 1'b1; s_wdata = data; s_wstrb = strb;
        #1;
        check({name, " aw/w ready"}, {s_awready, s_wready}, 2'b11);
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        watch_write(name, addr >> 2, data, ok);
    endtask

    task automatic read_txn(input string name, input logic [31:0] addr, input logic [31:0] msg,
                            input int stall, input logic ok);
        s_arvalid = 1'b1; s_araddr = addr;
        #1;
        check({name, " readies"}, {s_awready, s_wready, s_arready}, 3'b001);
        @(negedge clk);
        s_arvalid = 1'b0;
        watch_read(name, addr >> 2, msg, stall, ok);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{"wr_08",     1'b0, 32'h08, 32'hDEADBEEF, 4'hF, 0, 1'b1};
        vecs[1] = '{"wr_24",     1'b0, 32'h24, 32'h0BADF00D, 4'hF, 0, 1'b1};
        vecs[2] = '{"wr_strb3",  1'b0, 32'h08, 32'hCAFEF00D, 4'h3, 0, 1'b0};
        vecs[3] = '{"wr_idle",   1'b0, 32'h00, 32'h01020304, 4'hF, 0, 1'b0};
        vecs[4] = '{"wr_misal",  1'b0, 32'h0D, 32'h55667788, 4'hF, 0, 1'b0};
        vecs[5] = '{"rd_10",     1'b1, 32'h10, 32'hA5A5A5A5, 4'h0, 5, 1'b1};
        vecs[6] = '{"rd_02",     1'b1, 32'h02, 32'h77777777, 4'h0, 0, 1'b0};
        vecs[7] = '{"rd_idle",   1'b1, 32'h00, 32'h88888888, 4'h0, 0, 1'b0};
        vecs[8] = '{"rd_40",     1'b1, 32'h40, 32'h13579BDF, 4'h0, 2, 1'b1};

        #12;
        check("reset readies", {s_awready, s_wready, s_arready}, 3'b000);
        check("reset valids", {s_bvalid, s_rvalid}, 2'b00);
        check("reset resp/rdata", {s_bresp, s_rresp, s_rdata}, 36'd0);
        check("reset wr_addr", axi_wr_addr, IDLE);
        check("reset rd_addr", axi_rd_addr, IDLE);
        check("reset wr_msg", axi_wr_msg, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].is_rd)
                read_txn(vecs[i].name, vecs[i].addr, vecs[i].data, vecs[i].stall, vecs[i].ok);
            else
                write_txn(vecs[i].name, vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].ok);
        end

        // W arrives three cycles ahead of AW.
        s_wvalid = 1'b1; s_wdata = 32'h12345678; s_wstrb = 4'hF;
        #1 check("wfirst readies", {s_awready, s_wready, s_arready}, 3'b111);
        @(negedge clk);
        s_wvalid = 1'b0;
        #1 check("wfirst parked", {s_awready, s_wready, s_arready}, 3'b100);
        repeat (2) @(negedge clk);
        s_awvalid = 1'b1; s_awaddr = 32'h0C;
        #1 check("wfirst awready", s_awready, 1'b1);
        @(negedge clk);
        s_awvalid = 1'b0;
        watch_write("wfirst", 32'd3, 32'h12345678, 1'b1);

        // Contention 1: write has priority, read waits with arready low.
        s_awvalid = 1'b1; s_awaddr = 32'h14; s_wvalid = 1'b1; s_wdata = 32'h11112222;
        s_wstrb = 4'hF; s_arvalid = 1'b1; s_araddr = 32'h18;
        #1 check("cont1 readies", {s_awready, s_wready, s_arready}, 3'b110);
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        #1 check("cont1 loser arready", s_arready, 1'b0);
        watch_write("cont1_wr", 32'd5, 32'h11112222, 1'b1);
        #1 check("cont1 late arready", s_arready, 1'b1);
        @(negedge clk);
        s_arvalid = 1'b0;
        watch_read("cont1_rd", 32'd6, 32'h2468ACE0, 0, 1'b1);

        // Contention 2: read now has priority, write waits.
        s_awvalid = 1'b1; s_awaddr = 32'h1C; s_wvalid = 1'b1; s_wdata = 32'h33334444;
        s_arvalid = 1'b1; s_araddr = 32'h20;
        #1 check("cont2 readies", {s_awready, s_wready, s_arready}, 3'b001);
        @(negedge clk);
        s_arvalid = 1'b0;
        #1 check("cont2 loser ready", {s_awready, s_wready}, 2'b00);
        watch_read("cont2_rd", 32'd8, 32'h5555AAAA, 0, 1'b1);
        #1 check("cont2 late ready", {s_awready, s_wready}, 2'b11);
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        watch_write("cont2_wr", 32'd7, 32'h33334444, 1'b1);

        // Reset asserted while the read address is being held.
        s_arvalid = 1'b1; s_araddr = 32'h10;
        @(negedge clk);
        s_arvalid = 1'b0;
        #1 check("rst hold addr", axi_rd_addr, 32'd4);
        #2 reset = 1'b0;
        #1;
        check("rst rd_addr idle", axi_rd_addr, IDLE);
        check("rst rvalid", s_rvalid, 1'b0);
        repeat (2) @(negedge clk);
        check("rst rvalid later", s_rvalid, 1'b0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("post-rst rvalid", s_rvalid, 1'b0);
        read_txn("post_rst_rd", 32'h10, 32'h0F0F0F0F, 1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_lite_front.md
Name: axi_lite_front

Overview:
- AXI4-Lite slave front-end that sits directly upstream of the prewrapped DUFT block.
- Converts AXI4-Lite AW/W/B/AR/R channel transactions into the flat axi_wr_addr/axi_wr_msg/axi_rd_addr/axi_rd_msg command interface that prewrapped consumes.
- Serialises reads and writes, generates one-cycle write commands and fixed-latency read captures, and returns OKAY/SLVERR responses.

Parameters:
- ADDR_W, 32, width of AXI byte addresses s_awaddr/s_araddr.
- IDLE_ADDR, 32'd0, word address driven on axi_wr_addr/axi_rd_addr when no command is active; host access to it is rejected.
- RD_LAT, 2, cycles axi_rd_addr is held before axi_rd_msg is sampled (1..15).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- s_awvalid / s_awready  in / out  1 / 1  write address handshake
- s_awaddr  in  ADDR_W  write byte address
- s_wvalid / s_wready  in / out  1 / 1  write data handshake
- s_wdata  in  32  write data
- s_wstrb  in  4  byte strobes
- s_bvalid / s_bready  out / in  1 / 1  write response handshake
- s_bresp  out  2  00 OKAY, 10 SLVERR
- s_arvalid / s_arready  in / out  1 / 1  read address handshake
- s_araddr  in  ADDR_W  read byte address
- s_rvalid / s_rready  out / in  1 / 1  read data handshake
- s_rdata  out  32  read data
- s_rresp  out  2  00 OKAY, 10 SLVERR
- axi_wr_addr  out  32  word address to prewrapped, IDLE_ADDR when idle
- axi_wr_msg  out  32  write payload to prewrapped, 0 when idle
- axi_rd_addr  out  32  word address to prewrapped, IDLE_ADDR when idle
- axi_rd_msg  in  32  read payload from prewrapped

Behaviour:
- Reset (reset=0, async) applies the following values:
  - All ready/valid outputs 0; s_bresp, s_rresp, s_rdata 0.
  - axi_wr_addr and axi_rd_addr = IDLE_ADDR; axi_wr_msg 0.
  - FSM in IDLE; priority flag = write.
- Reset asserted mid-transaction aborts it: no command is issued and no response is produced.
- Word address = byte_addr[ADDR_W-1:2], zero-extended to 32 bits.
- FSM states: IDLE, WR_ISSUE, WR_RESP, RD_HOLD, RD_RESP.
- IDLE:
  - s_awready=1 and s_wready=1 independently until each channel is captured; AW and W may arrive in any order or cycle.
  - s_arready=1 only when no AW/W beat has been captured.
  - Once both AW and W are captured, go to WR_ISSUE. Once AR is captured, go to RD_HOLD.
  - Simultaneous complete write and arvalid in the same cycle: the priority flag selects. The flag toggles after each granted contention, so contended requests alternate write/read. The loser is not accepted (its ready stays 0).
- Write error check: SLVERR if s_wstrb != 4'hF, or awaddr[1:0] != 0, or word address == IDLE_ADDR. An erroring write skips WR_ISSUE and goes directly to WR_RESP.
- WR_ISSUE (exactly 1 cycle): axi_wr_addr = word address, axi_wr_msg = wdata. Next cycle both return to IDLE_ADDR/0. Then go to WR_RESP.
- WR_RESP: s_bvalid=1 with s_bresp held stable until s_bready; then return to IDLE.
- Read error check: SLVERR if araddr[1:0] != 0 or word address == IDLE_ADDR. An erroring read goes directly to RD_RESP with s_rdata=0.
- RD_HOLD:
  - axi_rd_addr = word address for RD_LAT cycles, counted by a 4-bit down-counter.
  - On the last cycle, capture axi_rd_msg into s_rdata.
  - axi_rd_addr returns to IDLE_ADDR on the next cycle; go to RD_RESP.
- RD_RESP: s_rvalid=1; s_rdata/s_rresp held stable until s_rready; then return to IDLE.
- Only one transaction is outstanding at a time; no new AW/W/AR is accepted outside IDLE.
- A ready/valid pair stalled by the host (bready/rready low) may stall indefinitely with no timeout.
- Latency, from the cycle in which the last of AW/W handshakes to first bvalid: 2 cycles on success, 1 cycle on error.
- Latency, from AR handshake to rvalid: RD_LAT+1 cycles.

Test Plan:
- AW 0x08 and W 0xDEADBEEF (wstrb F) in the same cycle, bready=1 -> axi_wr_addr=2, axi_wr_msg=0xDEADBEEF for exactly 1 cycle; bvalid 2 cycles later; bresp=00.
- W 0x12345678 three cycles before AW 0x0C -> single issue with axi_wr_addr=3, msg 0x12345678; bresp=00.
- AR 0x10, axi_rd_msg driven 0xA5A5A5A5 from cycle 2, RD_LAT=2 -> axi_rd_addr=4 for 2 cycles; rvalid 3 cycles after handshake; rdata=0xA5A5A5A5; rresp=00. Hold rready=0 for 5 cycles -> rdata stable.
- Write with wstrb=4'h3, write to 0x00, and read from 0x02 -> SLVERR (10); axi_wr_addr/axi_rd_addr never leave IDLE_ADDR.
- Complete write and AR in the same cycle, repeated twice -> first grant write, second grant read; loser's ready stays 0 until IDLE.
- Drive reset low during RD_HOLD -> rvalid stays 0, axi_rd_addr=IDLE_ADDR immediately; after release, a new read completes normally.
